// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode map, ALU operation codes, controller state and
// instruction-class enums shared by the multicycle controller and its decoder.
package ctrl_pkg;

    // Opcode map (low 16 codes of the opcode field)
    localparam logic [3:0] OP_LB   = 4'd0;
    localparam logic [3:0] OP_LIM  = 4'd1;
    localparam logic [3:0] OP_MVB  = 4'd2;
    localparam logic [3:0] OP_STR  = 4'd3;
    localparam logic [3:0] OP_MVF  = 4'd4;
    localparam logic [3:0] OP_SFT  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_LHB  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [3:0] OP_TBA  = 4'd15;

    // ALU operation codes driven on alu_inst
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SFL = 4'd2;
    localparam logic [3:0] ALU_SFR = 4'd3;
    localparam logic [3:0] ALU_INC = 4'd4;
    localparam logic [3:0] ALU_DEC = 4'd5;
    localparam logic [3:0] ALU_BNE = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd7;
    localparam logic [3:0] ALU_BLT = 4'd8;
    localparam logic [3:0] ALU_LHB = 4'd9;
    localparam logic [3:0] ALU_JMP = 4'd10;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    typedef enum logic [2:0] {
        ALU,
        BRANCH,
        LOAD,
        STORE,
        MOVE,
        NOP,
        HALT
    } inst_class_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational classification of a latched opcode and mode
// bit into an instruction class and the ALU operation it needs.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imm_flag,
    output inst_class_t         inst_class,
    output logic [ALUOP_W-1:0]  alu_inst
);

    logic [3:0] map_code;
    logic       out_of_map;

    assign map_code = opcode[3:0];

    // Codes above the 16-entry map behave as NOP; only wide opcode fields can reach them.
    if (OPCODE_W > 4) begin : g_wide_opcode
        assign out_of_map = |opcode[OPCODE_W-1:4];
    end else begin : g_narrow_opcode
        assign out_of_map = 1'b0;
    end

    // Map each opcode to its class and ALU operation; unknown codes fall back to NOP with ADD (0).
    always_comb begin
        inst_class = NOP;
        alu_inst   = '0;
        if (!out_of_map) begin
            case (map_code)
                OP_ADD:  begin inst_class = ALU;    alu_inst = ALUOP_W'(ALU_ADD); end
                OP_SUB:  begin inst_class = ALU;    alu_inst = ALUOP_W'(ALU_SUB); end
                OP_SFT:  begin inst_class = ALU;    alu_inst = imm_flag ? ALUOP_W'(ALU_SFR) : ALUOP_W'(ALU_SFL); end
                OP_INC:  begin inst_class = ALU;    alu_inst = imm_flag ? ALUOP_W'(ALU_INC) : ALUOP_W'(ALU_DEC); end
                OP_LHB:  begin inst_class = ALU;    alu_inst = ALUOP_W'(ALU_LHB); end
                OP_BNE:  begin inst_class = BRANCH; alu_inst = ALUOP_W'(ALU_BNE); end
                OP_BEQ:  begin inst_class = BRANCH; alu_inst = ALUOP_W'(ALU_BEQ); end
                OP_BLT:  begin inst_class = BRANCH; alu_inst = ALUOP_W'(ALU_BLT); end
                OP_JMP:  begin inst_class = BRANCH; alu_inst = ALUOP_W'(ALU_JMP); end
                OP_LB:   inst_class = LOAD;
                OP_STR:  inst_class = STORE;
                OP_LIM:  inst_class = MOVE;
                OP_MVB:  inst_class = MOVE;
                OP_MVF:  inst_class = MOVE;
                OP_HALT: inst_class = HALT;
                OP_TBA:  inst_class = NOP;
                default: inst_class = NOP;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequences each instruction through FETCH, DECODE, EXEC,
// MEM and WB with req/ack handshakes to instruction and data memory, plus
// HALT/resume. Optional feature macro CTRL_PERF_EN adds the retired_cnt port
// and its retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imm_flag,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    input  logic                resume,
    output logic                imem_req,
    output logic                ir_load,
    output logic                dmem_req,
    output logic                read_mem,
    output logic                write_mem,
    output logic                write_reg,
    output logic [ALUOP_W-1:0]  alu_inst,
    output logic                branch_chk,
    output logic                pc_en,
    output logic                halted
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    retired_cnt
`endif
);

    state_t              state;
    state_t              state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic                imm_q;
    inst_class_t         inst_class;
    logic [ALUOP_W-1:0]  dec_alu;

    control_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .opcode     (opcode_q),
        .imm_flag   (imm_q),
        .inst_class (inst_class),
        .alu_inst   (dec_alu)
    );

    // State register; reset abandons any instruction in flight and restarts at FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_d;
        end
    end

    // Capture the instruction fields once in DECODE so later states see a stable opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            imm_q    <= 1'b0;
        end else if (state == DECODE) begin
            opcode_q <= opcode;
            imm_q    <= imm_flag;
        end
    end

    // Next state and strobes; everything is forced low while reset is asserted.
    always_comb begin
        state_d    = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        write_reg  = 1'b0;
        alu_inst   = '0;
        branch_chk = 1'b0;
        pc_en      = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_load = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    state_d = EXEC;
                end
                EXEC: begin
                    alu_inst = dec_alu;
                    case (inst_class)
                        ALU, MOVE: state_d = WB;
                        BRANCH: begin
                            branch_chk = 1'b1;
                            pc_en      = 1'b1;
                            state_d    = FETCH;
                        end
                        LOAD, STORE: state_d = MEM;
                        HALT:  state_d = HALTED;
                        default: begin
                            pc_en   = 1'b1;
                            state_d = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    alu_inst  = dec_alu;
                    dmem_req  = 1'b1;
                    read_mem  = (inst_class == LOAD);
                    write_mem = (inst_class == STORE);
                    if (dmem_ack) begin
                        if (inst_class == LOAD) begin
                            state_d = WB;
                        end else begin
                            pc_en   = 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                WB: begin
                    alu_inst  = dec_alu;
                    write_reg = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = FETCH;
                end
                HALTED: begin
                    halted = 1'b1;
                    if (resume) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q;

    // Count retirements; the resume pulse restarts fetch but retires nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (pc_en && (state != HALTED)) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized driver with a scoreboard. The driver pushes
// the expected retirement of each instruction; a negedge monitor pops it on
// every pc_en and compares strobe activity, ALU op and retire cycle.
module tb_multicycle_control;

    localparam int OPCODE_W = 4;
    localparam int ALUOP_W  = 4;
    localparam int CNT_W    = 4;

    localparam logic [3:0] LB   = 4'd0;
    localparam logic [3:0] LIM  = 4'd1;
    localparam logic [3:0] MVB  = 4'd2;
    localparam logic [3:0] STR  = 4'd3;
    localparam logic [3:0] MVF  = 4'd4;
    localparam logic [3:0] SFT  = 4'd5;
    localparam logic [3:0] INC  = 4'd6;
    localparam logic [3:0] ADD  = 4'd7;
    localparam logic [3:0] SUB  = 4'd8;
    localparam logic [3:0] LHB  = 4'd9;
    localparam logic [3:0] BNE  = 4'd10;
    localparam logic [3:0] BEQ  = 4'd11;
    localparam logic [3:0] BLT  = 4'd12;
    localparam logic [3:0] JMP  = 4'd13;
    localparam logic [3:0] HALT = 4'd14;
    localparam logic [3:0] TBA  = 4'd15;

    typedef struct {
        int op;
        int alu;
        int wr;
        int br;
        int rd;
        int wm;
        int im;
        int halt;
        int retire;
        bit is_resume;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [OPCODE_W-1:0] opcode = '0;
    logic                imm_flag = 1'b0;
    logic                imem_ack = 1'b0;
    logic                dmem_ack = 1'b0;
    logic                resume = 1'b0;
    logic                imem_req, ir_load, dmem_req, read_mem, write_mem;
    logic                write_reg, branch_chk, pc_en, halted;
    logic [ALUOP_W-1:0]  alu_inst;
`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0]    retired_cnt;
    int                  model_cnt = 0;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   aborted = 1'b0;
    exp_t exp_q[$];
    int   acc_im, acc_ir, acc_dreq, acc_rd, acc_wm, acc_wr, acc_br, acc_halt;

    multicycle_control #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .imm_flag    (imm_flag),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .resume      (resume),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .dmem_req    (dmem_req),
        .read_mem    (read_mem),
        .write_mem   (write_mem),
        .write_reg   (write_reg),
        .alu_inst    (alu_inst),
        .branch_chk  (branch_chk),
        .pc_en       (pc_en),
        .halted      (halted)
`ifdef CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: what retirement of one instruction must look like,
    // given the ack wait counts the driver will apply.
    function automatic exp_t model(input logic [3:0] op, input logic imm, input int d1,
                                   input int d2, input int k, input int fcyc);
        exp_t e;
        int   extra;
        e.op = int'(op); e.alu = 0; e.wr = 0; e.br = 0; e.rd = 0; e.wm = 0;
        e.halt = 0; e.is_resume = 1'b0;
        extra = 0;
        case (op)
            ADD:           begin e.alu = 0;             e.wr = 1; extra = 1; end
            SUB:           begin e.alu = 1;             e.wr = 1; extra = 1; end
            SFT:           begin e.alu = imm ? 3 : 2;   e.wr = 1; extra = 1; end
            INC:           begin e.alu = imm ? 4 : 5;   e.wr = 1; extra = 1; end
            LHB:           begin e.alu = 9;             e.wr = 1; extra = 1; end
            LIM, MVB, MVF: begin e.alu = 0;             e.wr = 1; extra = 1; end
            BNE:           begin e.alu = 6;  e.br = 1; end
            BEQ:           begin e.alu = 7;  e.br = 1; end
            BLT:           begin e.alu = 8;  e.br = 1; end
            JMP:           begin e.alu = 10; e.br = 1; end
            LB:            begin e.rd = d2 + 1; e.wr = 1; extra = d2 + 2; end
            STR:           begin e.wm = d2 + 1; extra = d2 + 1; end
            HALT:          begin e.halt = k + 1; e.is_resume = 1'b1; extra = k + 1; end
            default:       extra = 0;
        endcase
        e.im     = d1 + 1;
        e.retire = fcyc + (d1 + 1) + 2 + extra - 1;
        return e;
    endfunction

    task automatic clearAcc();
        acc_im = 0; acc_ir = 0; acc_dreq = 0; acc_rd = 0;
        acc_wm = 0; acc_wr = 0; acc_br = 0; acc_halt = 0;
    endtask

    // Monitor: accumulate strobe activity and score each retirement.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            clearAcc();
`ifdef CTRL_PERF_EN
            model_cnt = 0;
`endif
        end else begin
            acc_im   += int'(imem_req);
            acc_ir   += int'(ir_load);
            acc_dreq += int'(dmem_req);
            acc_rd   += int'(read_mem);
            acc_wm   += int'(write_mem);
            acc_wr   += int'(write_reg);
            acc_br   += int'(branch_chk);
            acc_halt += int'(halted);
            tests++;
            if (int'(write_reg) + int'(write_mem) + int'(read_mem) > 1) begin
                fails++;
                $display("[TB] FAIL strobe_exclusive: got wr=%0d wm=%0d rd=%0d, expected at most one (cycle %0d)",
                         write_reg, write_mem, read_mem, cyc);
            end
            if (pc_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_pc_en: got pc_en=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("op%0d.retire_cycle", e.op), cyc, e.retire);
                    checkOutput($sformatf("op%0d.alu_inst", e.op), int'(alu_inst), e.alu);
                    checkOutput($sformatf("op%0d.write_reg_cycles", e.op), acc_wr, e.wr);
                    checkOutput($sformatf("op%0d.branch_chk_cycles", e.op), acc_br, e.br);
                    checkOutput($sformatf("op%0d.read_mem_cycles", e.op), acc_rd, e.rd);
                    checkOutput($sformatf("op%0d.write_mem_cycles", e.op), acc_wm, e.wm);
                    checkOutput($sformatf("op%0d.dmem_req_cycles", e.op), acc_dreq, e.rd + e.wm);
                    checkOutput($sformatf("op%0d.imem_req_cycles", e.op), acc_im, e.im);
                    checkOutput($sformatf("op%0d.ir_load_pulses", e.op), acc_ir, 1);
                    checkOutput($sformatf("op%0d.halted_cycles", e.op), acc_halt, e.halt);
`ifdef CTRL_PERF_EN
                    checkOutput("retired_cnt", int'(retired_cnt), model_cnt);
                    if (!e.is_resume) model_cnt = (model_cnt + 1) % (1 << CNT_W);
`endif
                end
                clearAcc();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitFetch(output bit ok);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        ok = (imem_req === 1'b1);
        if (!ok) begin
            tests++;
            fails++;
            aborted = 1'b1;
            $display("[TB] FAIL fetch_timeout: got imem_req=%0d, expected 1 within 60 cycles", imem_req);
        end else begin
            opcode = OPCODE_W'($urandom_range(0, 15));
        end
    endtask

    // Drive one instruction: d1/d2 wait cycles before imem/dmem ack, k extra HALTED cycles.
    task automatic applyStimulus(input logic [3:0] op, input logic imm, input int d1,
                                 input int d2, input int k);
        bit ok;
        int fcyc;
        if (aborted) return;
        waitFetch(ok);
        if (!ok) return;
        fcyc = cyc;
        repeat (d1) step();
        opcode   = OPCODE_W'(op);
        imm_flag = imm;
        imem_ack = 1'b1;
        exp_q.push_back(model(op, imm, d1, d2, k, fcyc));
        step();
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        step();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (op == LB || op == STR) begin
            step();
            repeat (d2) step();
            dmem_ack = 1'b1;
            step();
            dmem_ack = 1'b0;
        end else if (op == HALT) begin
            step();
            repeat (k) step();
            resume = 1'b1;
            step();
            resume = 1'b0;
        end
    endtask

    function automatic int allOutputs();
        return int'({imem_req, ir_load, dmem_req, read_mem, write_mem, write_reg,
                     branch_chk, pc_en, halted, alu_inst});
    endfunction

    // Start an LB, pull reset in its second MEM cycle, and expect a clean restart.
    task automatic resetDuringMem();
        bit ok;
        if (aborted) return;
        waitFetch(ok);
        if (!ok) return;
        opcode   = OPCODE_W'(LB);
        imm_flag = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        step();
        checkOutput("lb_mem.dmem_req", int'(dmem_req), 1);
        checkOutput("lb_mem.read_mem", int'(read_mem), 1);
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_mem.outputs", allOutputs(), 0);
        step();
        step();
        checkOutput("reset_held.outputs", allOutputs(), 0);
`ifdef CTRL_PERF_EN
        checkOutput("reset_held.retired_cnt", int'(retired_cnt), 0);
`endif
        rst_n = 1'b1;
        #1;
        checkOutput("after_release.imem_req", int'(imem_req), 1);
        checkOutput("after_release.ir_load", int'(ir_load), 0);
    endtask

    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n;
        clearAcc();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.outputs", allOutputs(), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_release.imem_req", int'(imem_req), 1);

        applyStimulus(ADD, 1'b0, 0, 0, 0);
        applyStimulus(LB, 1'b0, 0, 2, 0);
        applyStimulus(BEQ, 1'b0, 1, 0, 0);
        applyStimulus(STR, 1'b0, 0, 2, 0);
        applyStimulus(SFT, 1'b1, 0, 0, 0);
        applyStimulus(SFT, 1'b0, 0, 0, 0);
        applyStimulus(INC, 1'b1, 0, 0, 0);
        applyStimulus(INC, 1'b0, 2, 0, 0);
        applyStimulus(HALT, 1'b0, 0, 0, 10);
        applyStimulus(JMP, 1'b1, 0, 0, 0);
        resetDuringMem();
        for (int i = 0; i < 17; i++) applyStimulus(TBA, 1'b0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5));
        end

        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
